// File: rtl/misr_pkg.sv
// Shared definitions for the LED signature MISR: FSM states,
// feedback polynomial and default seed.
package misr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_CAPTURE,
        ST_DONE
    } misr_state_e;

    localparam logic [31:0] POLY         = 32'h04C11DB7;
    localparam logic [31:0] SEED_DEFAULT = 32'hFFFFFFFF;

endpackage

// File: rtl/misr_step.sv
// Combinational MISR step: shift left, fold in the polynomial on
// MSB carry-out, then xor in the incoming response word.
module misr_step
    import misr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_sig,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_next
);

    localparam logic [DATA_W-1:0] W_POLY = DATA_W'(POLY);

    logic [DATA_W-1:0] w_fb;

    assign w_fb   = i_sig[DATA_W-1] ? W_POLY : '0;
    assign o_next = {i_sig[DATA_W-2:0], 1'b0} ^ w_fb ^ i_data;

endmodule

// File: rtl/led_signature_misr.sv
// Captures a window of LED-bus responses into a MISR signature and
// compares it with a golden value at the end of each run.
module led_signature_misr
    import misr_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter int                SKIP   = 4,
    parameter int                WINDOW = 128,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(SEED_DEFAULT)
) (
    input  logic              CLK100MHZ,
    input  logic              RST,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_vld_i,
    input  logic [DATA_W-1:0] golden_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] signature_o,
    output logic [15:0]       sample_cnt_o,
    output logic              match_o
);

    localparam logic [15:0] SKIP_LAST = 16'(SKIP - 1);
    localparam logic [15:0] WIN_LAST  = 16'(WINDOW - 1);

    misr_state_e       r_state;
    logic [DATA_W-1:0] r_sig;
    logic [15:0]       r_cnt;
    logic [15:0]       r_skip;
    logic              r_busy;
    logic              r_done;
    logic              r_match;
    logic [DATA_W-1:0] w_next;

    misr_step #(.DATA_W(DATA_W)) u_step (
        .i_sig  (r_sig),
        .i_data (data_i),
        .o_next (w_next)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_sig   <= SEED;
            r_cnt   <= '0;
            r_skip  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_match <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_sig   <= SEED;
                        r_cnt   <= '0;
                        r_skip  <= '0;
                        r_match <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= (SKIP == 0) ? ST_CAPTURE : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (data_vld_i) begin
                        r_skip <= r_skip + 16'd1;
                        if (r_skip == SKIP_LAST) begin
                            r_state <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (data_vld_i) begin
                        r_sig <= w_next;
                        r_cnt <= r_cnt + 16'd1;
                        // last sample of the window is already included
                        if (r_cnt == WIN_LAST) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_match <= (r_sig == golden_i);
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign signature_o  = r_sig;
    assign sample_cnt_o = r_cnt;
    assign match_o      = r_match;

endmodule

// File: tb/tb_led_signature_misr.sv
// Directed bench for led_signature_misr: two instances (short and
// long window) with queued expected signatures checked on done_o.
module tb_led_signature_misr;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0;
    logic        start1;
    logic [31:0] data;
    logic        vld;
    logic [31:0] golden;

    logic        busy0, done0, match0;
    logic [31:0] sig0;
    logic [15:0] cnt0;
    logic        busy1, done1, match1;
    logic [31:0] sig1;
    logic [15:0] cnt1;

    int vectors     = 0;
    int miscompares = 0;
    int n_done0     = 0;
    int n_done1     = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    led_signature_misr #(.DATA_W(32), .SKIP(0), .WINDOW(1)) dut0 (
        .CLK100MHZ    (clk),
        .RST          (rst),
        .start_i      (start0),
        .data_i       (data),
        .data_vld_i   (vld),
        .golden_i     (golden),
        .busy_o       (busy0),
        .done_o       (done0),
        .signature_o  (sig0),
        .sample_cnt_o (cnt0),
        .match_o      (match0)
    );

    led_signature_misr #(.DATA_W(32), .SKIP(4), .WINDOW(128)) dut1 (
        .CLK100MHZ    (clk),
        .RST          (rst),
        .start_i      (start1),
        .data_i       (data),
        .data_vld_i   (vld),
        .golden_i     (golden),
        .busy_o       (busy1),
        .done_o       (done1),
        .signature_o  (sig1),
        .sample_cnt_o (cnt1),
        .match_o      (match1)
    );

    function automatic logic [31:0] ref_step(logic [31:0] s,
                                             logic [31:0] d);
        logic [31:0] r;
        r = {s[30:0], 1'b0};
        if (s[31]) r = r ^ 32'h04C11DB7;
        return r ^ d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (done0) begin
            n_done0++;
            check("done0_not_busy", {31'b0, busy0}, 32'd0);
            if (q0.size() == 0) check("q0_unexpected_done", 32'd1, 32'd0);
            else check("sig0_scoreboard", sig0, q0.pop_front());
        end
        if (done1) begin
            n_done1++;
            check("done1_not_busy", {31'b0, busy1}, 32'd0);
            if (q1.size() == 0) check("q1_unexpected_done", 32'd1, 32'd0);
            else check("sig1_scoreboard", sig1, q1.pop_front());
        end
    end

    initial begin
        logic [31:0] exp1;
        int          n;
        int          cyc;
        int          busy_bad;
        int          d0_before;

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        data = '0; vld = 1'b0; golden = '0;
        tick(); tick();
        check("rst_sig0", sig0, 32'hFFFFFFFF);
        check("rst_cnt0", {16'b0, cnt0}, 32'd0);
        check("rst_flags0", {29'b0, busy0, done0, match0}, 32'd0);
        check("rst_sig1", sig1, 32'hFFFFFFFF);
        check("rst_flags1", {29'b0, busy1, done1, match1}, 32'd0);
        rst = 1'b0;
        tick();

        // zero word, golden mismatch
        golden = 32'h0;
        q0.push_back(32'hFB3EE249);
        start0 = 1'b1; tick(); start0 = 1'b0;
        check("w1_busy", {31'b0, busy0}, 32'd1);
        data = 32'h0; vld = 1'b1; tick(); vld = 1'b0;
        check("w1_done", {31'b0, done0}, 32'd1);
        check("w1_sig_zero", sig0, 32'hFB3EE249);
        check("w1_cnt", {16'b0, cnt0}, 32'd1);
        tick();
        check("w1_done_pulse", {31'b0, done0}, 32'd0);
        check("w1_match_zero", {31'b0, match0}, 32'd0);

        // all-ones word, golden match
        golden = 32'h04C11DB6;
        q0.push_back(32'h04C11DB6);
        start0 = 1'b1; tick(); start0 = 1'b0;
        check("w1_match_clr", {31'b0, match0}, 32'd0);
        data = 32'hFFFFFFFF; vld = 1'b1; tick(); vld = 1'b0;
        check("w1_sig_ones", sig0, 32'h04C11DB6);
        tick();
        check("w1_match_one", {31'b0, match0}, 32'd1);
        tick(); tick();
        check("w1_hold_sig", sig0, 32'h04C11DB6);
        check("w1_hold_match", {31'b0, match0}, 32'd1);

        // same word, golden zero
        golden = 32'h0;
        q0.push_back(32'h04C11DB6);
        start0 = 1'b1; tick(); start0 = 1'b0;
        data = 32'hFFFFFFFF; vld = 1'b1; tick(); vld = 1'b0;
        tick();
        check("w1_match_golden0", {31'b0, match0}, 32'd0);

        // long window with random stalls, data = valid sample index
        exp1 = 32'hFFFFFFFF;
        for (int i = 5; i <= 132; i++) exp1 = ref_step(exp1, 32'(i));
        q1.push_back(exp1);
        golden = exp1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        n = 1; cyc = 0; busy_bad = 0;
        while (n <= 132 && cyc < 2000) begin
            vld  = 1'($urandom_range(0, 1));
            data = 32'(n);
            if (!busy1) busy_bad++;
            tick();
            if (vld) n++;
            cyc++;
        end
        vld = 1'b0;
        check("w128_timeout", 32'(n), 32'd133);
        check("w128_busy_thru", 32'(busy_bad), 32'd0);
        tick(); tick(); tick();
        check("w128_one_done", 32'(n_done1), 32'd1);
        check("w128_cnt", {16'b0, cnt1}, 32'd128);
        check("w128_match", {31'b0, match1}, 32'd1);
        check("w128_idle", {31'b0, busy1}, 32'd0);
        check("w128_hold_sig", sig1, exp1);

        // reset mid-run after 50 compacted samples
        start1 = 1'b1; tick(); start1 = 1'b0;
        vld = 1'b1;
        for (int i = 0; i < 54; i++) begin
            data = 32'(i * 7 + 3);
            tick();
        end
        vld = 1'b0;
        check("abort_cnt50", {16'b0, cnt1}, 32'd50);
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort_sig", sig1, 32'hFFFFFFFF);
        check("abort_cnt", {16'b0, cnt1}, 32'd0);
        check("abort_busy", {31'b0, busy1}, 32'd0);
        check("abort_match", {31'b0, match1}, 32'd0);
        tick(); tick();
        check("abort_no_done", 32'(n_done1), 32'd1);

        // reset wins over start
        rst = 1'b1; start1 = 1'b1; start0 = 1'b1; tick();
        rst = 1'b0; start1 = 1'b0; start0 = 1'b0;
        check("rst_prio_busy1", {31'b0, busy1}, 32'd0);
        check("rst_prio_busy0", {31'b0, busy0}, 32'd0);
        tick();

        // start held high: back-to-back runs on identical data
        d0_before = n_done0;
        data = 32'h12345678; vld = 1'b1;
        for (int i = 0; i < 3; i++)
            q0.push_back(ref_step(32'hFFFFFFFF, 32'h12345678));
        start0 = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        start0 = 1'b0; vld = 1'b0;
        tick(); tick();
        check("held_start_runs", 32'(n_done0 - d0_before), 32'd3);
        check("held_start_sig", sig0,
              ref_step(32'hFFFFFFFF, 32'h12345678));
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
